// File: rtl/arb_merge_pkg.sv
// arb_merge_pkg
//   Shared constants and helpers for the N-to-1 arbitrated merge block.
//   ARB_FIXED / ARB_RR select the arbitration policy of arb_merge_n.
//   clog2() returns ceil(log2(n)) but never less than 1, so that it can be
//   used directly as the width of an index or pointer field.
package arb_merge_pkg;

   localparam int ARB_FIXED = 0;
   localparam int ARB_RR    = 1;

   function automatic int clog2(input int n);
      int r;
      r = 0;
      while ((1 << r) < n) begin
         r = r + 1;
      end
      return (r < 1) ? 1 : r;
   endfunction

endpackage

// File: rtl/arb_merge_fifo.sv
// arb_merge_fifo
//   Single-clock per-channel word buffer used by arb_merge_n.
//   Ports:
//     clk, rstn      clock, asynchronous active-low reset (empties the buffer)
//     push, wdata    write request and word; ignored while full
//     pop            read request; ignored while empty
//     full, empty    occupancy flags, decoded from the registered count
//     head           oldest word held (undefined while empty)
//   Simultaneous push and pop below full leaves the count unchanged.
module arb_merge_fifo
   import arb_merge_pkg::*;
#(
   parameter int DATA_WIDTH = 32,
   parameter int DEPTH      = 2
) (
   input  logic                  clk,
   input  logic                  rstn,
   input  logic                  push,
   input  logic [DATA_WIDTH-1:0] wdata,
   input  logic                  pop,
   output logic                  full,
   output logic                  empty,
   output logic [DATA_WIDTH-1:0] head
);

   localparam int PW = clog2(DEPTH);
   localparam int CW = clog2(DEPTH + 1);
   localparam logic [PW-1:0] PTR_LAST = PW'(DEPTH - 1);
   localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);

   // Storage is sized to the pointer range so a DEPTH of 1 still indexes
   // cleanly; the pointer wrap below keeps accesses inside DEPTH entries.
   logic [DATA_WIDTH-1:0] mem [2**PW];
   logic [PW-1:0]         wr_ptr;
   logic [PW-1:0]         rd_ptr;
   logic [CW-1:0]         count;
   logic                  do_push;
   logic                  do_pop;

   function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
      return (p == PTR_LAST) ? '0 : p + PW'(1);
   endfunction

   assign full    = (count == CNT_FULL);
   assign empty   = (count == '0);
   assign do_push = push & ~full;
   assign do_pop  = pop & ~empty;
   assign head    = mem[rd_ptr];

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) begin
            wr_ptr <= ptr_inc(wr_ptr);
         end
         if (do_pop) begin
            rd_ptr <= ptr_inc(rd_ptr);
         end
         case ({do_push, do_pop})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
      end
   end

   // Data array carries no reset; validity is tracked entirely by count.
   always_ff @(posedge clk) begin
      if (do_push) begin
         mem[wr_ptr] <= wdata;
      end
   end

endmodule

// File: rtl/arb_merge_n.sv
// arb_merge_n
//   Merges NUM_CH valid/ready word streams into one output stream.
//   Each channel has its own DEPTH-word buffer; an arbiter picks one
//   non-empty buffer whenever the output register is empty or draining.
//   Ports:
//     clk, rstn     clock, asynchronous active-low reset
//     i_drive_n     per-channel word valid
//     i_data        channel k word at [k*DATA_WIDTH +: DATA_WIDTH]
//     o_free_n      per-channel ready (buffer not full, registered only)
//     o_driveNext   output word valid
//     o_data        output word
//     o_src_id      channel the output word came from
//     i_freeNext    downstream ready
//   ARB_MODE: ARB_FIXED = lowest index wins, ARB_RR = rotating priority.
module arb_merge_n
   import arb_merge_pkg::*;
#(
   parameter int DATA_WIDTH = 32,
   parameter int NUM_CH     = 4,
   parameter int DEPTH      = 2,
   parameter int ARB_MODE   = ARB_FIXED,
   localparam int ID_W      = clog2(NUM_CH)
) (
   input  logic                         clk,
   input  logic                         rstn,
   input  logic [NUM_CH-1:0]            i_drive_n,
   input  logic [NUM_CH*DATA_WIDTH-1:0] i_data,
   output logic [NUM_CH-1:0]            o_free_n,
   output logic                         o_driveNext,
   output logic [DATA_WIDTH-1:0]        o_data,
   output logic [ID_W-1:0]              o_src_id,
   input  logic                         i_freeNext
);

   logic [NUM_CH-1:0]     ch_full;
   logic [NUM_CH-1:0]     ch_empty;
   logic [NUM_CH-1:0]     ch_push;
   logic [NUM_CH-1:0]     ch_pop;
   logic [DATA_WIDTH-1:0] ch_head [NUM_CH];

   logic                  out_load;
   logic                  gnt_vld;
   logic [ID_W-1:0]       gnt_id;
   logic [DATA_WIDTH-1:0] gnt_data;
   logic [ID_W-1:0]       rr_ptr;

   // Ready depends only on buffer occupancy, so there is no combinational
   // path from i_drive_n or i_freeNext to o_free_n.
   assign o_free_n = ~ch_full;
   assign ch_push  = i_drive_n & ~ch_full;

   // Output register refills when empty or when its word leaves this cycle.
   assign out_load = ~o_driveNext | i_freeNext;

   for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
      arb_merge_fifo #(
         .DATA_WIDTH (DATA_WIDTH),
         .DEPTH      (DEPTH)
      ) u_fifo (
         .clk   (clk),
         .rstn  (rstn),
         .push  (ch_push[k]),
         .wdata (i_data[k*DATA_WIDTH +: DATA_WIDTH]),
         .pop   (ch_pop[k]),
         .full  (ch_full[k]),
         .empty (ch_empty[k]),
         .head  (ch_head[k])
      );
   end

   // Round-robin: first search channels at or above the pointer, then fall
   // back to a plain lowest-index search, which covers the wrapped part.
   // Fixed priority uses only the second search.
   always_comb begin
      gnt_vld  = 1'b0;
      gnt_id   = '0;
      gnt_data = '0;
      if (ARB_MODE == ARB_RR) begin
         for (int k = 0; k < NUM_CH; k++) begin
            if (!gnt_vld && !ch_empty[k] && (ID_W'(k) >= rr_ptr)) begin
               gnt_vld  = 1'b1;
               gnt_id   = ID_W'(k);
               gnt_data = ch_head[k];
            end
         end
      end
      for (int k = 0; k < NUM_CH; k++) begin
         if (!gnt_vld && !ch_empty[k]) begin
            gnt_vld  = 1'b1;
            gnt_id   = ID_W'(k);
            gnt_data = ch_head[k];
         end
      end
   end

   always_comb begin
      ch_pop = '0;
      for (int k = 0; k < NUM_CH; k++) begin
         ch_pop[k] = out_load & gnt_vld & (gnt_id == ID_W'(k));
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         o_driveNext <= 1'b0;
         o_data      <= '0;
         o_src_id    <= '0;
      end else if (out_load) begin
         o_driveNext <= gnt_vld;
         if (gnt_vld) begin
            o_data   <= gnt_data;
            o_src_id <= gnt_id;
         end
      end
   end

   // Pointer only moves on an actual grant.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         rr_ptr <= '0;
      end else if ((ARB_MODE == ARB_RR) && out_load && gnt_vld) begin
         rr_ptr <= (gnt_id == ID_W'(NUM_CH - 1)) ? '0 : gnt_id + ID_W'(1);
      end
   end

endmodule

// File: tb/tb_arb_merge_n.sv
module tb_arb_merge_n;

   localparam int NCH = 4;
   localparam int DW  = 32;
   localparam int DEP = 2;
   localparam int WORDS = 10000;
   localparam int BUDGET = 40000;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic              rstn;
   logic [NCH-1:0]    drv;
   logic [NCH*DW-1:0] din;
   logic              rdy;

   logic           v_f, v_r;
   logic [DW-1:0]  d_f, d_r;
   logic [1:0]     s_f, s_r;
   logic [NCH-1:0] f_f, f_r;

   arb_merge_n #(.DATA_WIDTH(DW), .NUM_CH(NCH), .DEPTH(DEP), .ARB_MODE(0)) u_fix (
      .clk(clk), .rstn(rstn), .i_drive_n(drv), .i_data(din), .o_free_n(f_f),
      .o_driveNext(v_f), .o_data(d_f), .o_src_id(s_f), .i_freeNext(rdy));

   arb_merge_n #(.DATA_WIDTH(DW), .NUM_CH(NCH), .DEPTH(DEP), .ARB_MODE(1)) u_rr (
      .clk(clk), .rstn(rstn), .i_drive_n(drv), .i_data(din), .o_free_n(f_r),
      .o_driveNext(v_r), .o_data(d_r), .o_src_id(s_r), .i_freeNext(rdy));

   // index 0 = fixed-priority instance, 1 = round-robin instance
   logic           dv [2];
   logic [DW-1:0]  dd [2];
   logic [1:0]     ds [2];
   logic [NCH-1:0] df [2];
   always_comb begin
      dv[0] = v_f; dd[0] = d_f; ds[0] = s_f; df[0] = f_f;
      dv[1] = v_r; dd[1] = d_r; ds[1] = s_r; df[1] = f_r;
   end

   int checks = 0;
   int failures = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   function automatic string sfx(input int m);
      return (m == 0) ? "_fix" : "_rr";
   endfunction

   // ---------------- reference model ----------------
   // Per-channel queues of accepted words, an output slot, and a rotating
   // priority index; advanced once per rising edge from the pre-edge inputs.
   logic [DW-1:0] mq [2][NCH][$];
   bit            mv [2];
   logic [DW-1:0] md [2];
   int            ms [2];
   int            mp [2];
   int            acc [2];
   int            dlv [2];
   bit            chk_en = 1'b0;

   always @(posedge clk or negedge rstn) begin
      bit fr [NCH];
      int g;
      int k;
      if (!rstn) begin
         for (int m = 0; m < 2; m++) begin
            for (int c = 0; c < NCH; c++) mq[m][c].delete();
            mv[m] = 1'b0; md[m] = '0; ms[m] = 0; mp[m] = 0; acc[m] = 0; dlv[m] = 0;
         end
      end else begin
         for (int m = 0; m < 2; m++) begin
            if (dv[m] && rdy) dlv[m]++;
            for (int c = 0; c < NCH; c++) fr[c] = (mq[m][c].size() < DEP);
            if (!mv[m] || rdy) begin
               g = -1;
               for (int j = 0; j < NCH; j++) begin
                  k = (m == 1) ? (mp[m] + j) % NCH : j;
                  if (g < 0 && mq[m][k].size() > 0) g = k;
               end
               if (g >= 0) begin
                  md[m] = mq[m][g].pop_front();
                  ms[m] = g;
                  mv[m] = 1'b1;
                  if (m == 1) mp[m] = (g + 1) % NCH;
               end else begin
                  mv[m] = 1'b0;
               end
            end
            for (int c = 0; c < NCH; c++) begin
               if (drv[c] && fr[c]) begin
                  mq[m][c].push_back(din[c*DW +: DW]);
                  acc[m]++;
               end
            end
         end
      end
   end

   always @(negedge clk) begin
      logic [63:0]    ca, ce;
      logic [NCH-1:0] mf;
      if (chk_en && rstn) begin
         for (int m = 0; m < 2; m++) begin
            for (int c = 0; c < NCH; c++) mf[c] = (mq[m][c].size() < DEP);
            ce = {25'b0, mv[m], mf, mv[m] ? 2'(ms[m]) : 2'b0, mv[m] ? md[m] : 32'b0};
            ca = {25'b0, dv[m], df[m], dv[m] ? ds[m] : 2'b0, dv[m] ? dd[m] : 32'b0};
            check({"model", sfx(m)}, ca, ce);
         end
      end
   end

   // ---------------- helpers ----------------
   task automatic reset_dut();
      drv = '0; din = '0; rdy = 1'b0;
      @(negedge clk);
      rstn = 1'b0;
      repeat (2) @(negedge clk);
      rstn = 1'b1;
   endtask

   task automatic check_reset(input string name);
      for (int m = 0; m < 2; m++) begin
         check({name, sfx(m), "_valid"}, dv[m], 0);
         check({name, sfx(m), "_data"},  dd[m], 0);
         check({name, sfx(m), "_src"},   ds[m], 0);
         check({name, sfx(m), "_free"},  df[m], 4'hF);
      end
   endtask

   task automatic expect_out(input string name, input logic ev, input logic [DW-1:0] ed,
                             input logic [1:0] es);
      for (int m = 0; m < 2; m++) begin
         check({name, sfx(m), "_valid"}, dv[m], ev);
         if (ev) begin
            check({name, sfx(m), "_data"}, dd[m], ed);
            check({name, sfx(m), "_src"},  ds[m], es);
         end
      end
   endtask

   task automatic expect_free(input string name, input logic [NCH-1:0] ef);
      for (int m = 0; m < 2; m++) check({name, sfx(m), "_free"}, df[m], ef);
   endtask

   task automatic set_din_a();
      for (int c = 0; c < NCH; c++) din[c*DW +: DW] = 32'hA0 + c;
   endtask

   typedef struct {
      logic [NCH-1:0] drv;
      logic           rdy;
      logic           ev;
      int             es_f;
      int             es_r;
      logic           chkf;
      logic [NCH-1:0] efree;
   } vec_t;

   vec_t tbl [$];

   // Each entry: inputs driven before an edge, outputs expected after it.
   task automatic run_table(input string name);
      for (int i = 0; i < tbl.size(); i++) begin
         drv = tbl[i].drv;
         rdy = tbl[i].rdy;
         @(negedge clk);
         for (int m = 0; m < 2; m++) begin
            int es;
            es = (m == 0) ? tbl[i].es_f : tbl[i].es_r;
            check($sformatf("%s_%0d%s_valid", name, i, sfx(m)), dv[m], tbl[i].ev);
            if (tbl[i].ev) begin
               check($sformatf("%s_%0d%s_data", name, i, sfx(m)), dd[m], 32'hA0 + es);
               check($sformatf("%s_%0d%s_src", name, i, sfx(m)), ds[m], es);
            end
            if (tbl[i].chkf)
               check($sformatf("%s_%0d%s_free", name, i, sfx(m)), df[m], tbl[i].efree);
         end
      end
   endtask

   // ---------------- test sequence ----------------
   initial begin
      int cyc;
      rstn = 1'b0; drv = '0; din = '0; rdy = 1'b0;
      #2;
      check_reset("reset_state");

      // all four channels push once, drained in index order
      reset_dut();
      set_din_a();
      tbl.delete();
      tbl.push_back('{4'hF, 1'b1, 1'b0, 0, 0, 1'b1, 4'hF});
      for (int i = 0; i < NCH; i++) tbl.push_back('{4'h0, 1'b1, 1'b1, i, i, 1'b1, 4'hF});
      tbl.push_back('{4'h0, 1'b1, 1'b0, 0, 0, 1'b1, 4'hF});
      run_table("burst4");

      // all channels continuously valid: fixed keeps serving ch0, RR rotates
      reset_dut();
      set_din_a();
      tbl.delete();
      tbl.push_back('{4'hF, 1'b1, 1'b0, 0, 0, 1'b1, 4'hF});
      for (int i = 0; i < 12; i++) tbl.push_back('{4'hF, 1'b1, 1'b1, 0, i % NCH, 1'b0, 4'h0});
      run_table("rotate");

      // channel 2 fills its buffer behind a held output word
      reset_dut();
      rdy = 1'b0; drv = 4'b0001; din[0*DW +: DW] = 32'h99;
      @(negedge clk); drv = '0;
      @(negedge clk);
      expect_out("full_hold99", 1'b1, 32'h99, 2'd0);
      drv = 4'b0100; din[2*DW +: DW] = 32'h11;
      @(negedge clk); din[2*DW +: DW] = 32'h22;
      @(negedge clk); din[2*DW +: DW] = 32'h33;
      expect_free("full_two_held", 4'b1011);
      @(negedge clk);
      expect_free("full_stall", 4'b1011);
      expect_out("full_still99", 1'b1, 32'h99, 2'd0);
      @(negedge clk);
      rdy = 1'b1;
      @(negedge clk);
      expect_out("full_out11", 1'b1, 32'h11, 2'd2);
      expect_free("full_slot", 4'b1111);
      @(negedge clk); drv = '0;
      expect_out("full_out22", 1'b1, 32'h22, 2'd2);
      @(negedge clk);
      expect_out("full_out33", 1'b1, 32'h33, 2'd2);
      @(negedge clk);
      expect_out("full_empty", 1'b0, '0, 2'd0);

      // downstream stall holds the output word steady
      reset_dut();
      rdy = 1'b0; drv = 4'hF;
      for (int c = 0; c < NCH; c++) din[c*DW +: DW] = 32'hB0 + c;
      @(negedge clk); drv = '0;
      @(negedge clk);
      expect_out("stall_load", 1'b1, 32'hB0, 2'd0);
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         expect_out($sformatf("stall_%0d", i), 1'b1, 32'hB0, 2'd0);
      end
      rdy = 1'b1;
      for (int i = 1; i < NCH; i++) begin
         @(negedge clk);
         expect_out($sformatf("stall_drain_%0d", i), 1'b1, 32'hB0 + i, 2'(i));
      end
      @(negedge clk);
      expect_out("stall_done", 1'b0, '0, 2'd0);

      // reset mid-operation with three words buffered
      reset_dut();
      rdy = 1'b0; drv = 4'b0111;
      for (int c = 0; c < NCH; c++) din[c*DW +: DW] = 32'hC0 + c;
      @(negedge clk); drv = '0;
      @(negedge clk);
      expect_out("mid_pre", 1'b1, 32'hC0, 2'd0);
      #2 rstn = 1'b0;
      #1 check_reset("mid_reset");
      @(negedge clk);
      rstn = 1'b1; rdy = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         expect_out($sformatf("mid_after_%0d", i), 1'b0, '0, 2'd0);
      end

      // random stress on both instances against the model
      reset_dut();
      chk_en = 1'b1;
      cyc = 0;
      while ((dlv[0] < WORDS || dlv[1] < WORDS) && cyc < BUDGET && failures < 200) begin
         drv = NCH'($urandom_range(0, 15));
         rdy = ($urandom_range(0, 9) < 7);
         for (int c = 0; c < NCH; c++) din[c*DW +: DW] = $urandom;
         @(negedge clk);
         cyc++;
      end
      check("stress_words_fix", (dlv[0] >= WORDS), 1);
      check("stress_words_rr",  (dlv[1] >= WORDS), 1);
      drv = '0; rdy = 1'b1;
      repeat (2 * NCH * DEP + 4) @(negedge clk);
      for (int m = 0; m < 2; m++) begin
         check({"stress_noloss", sfx(m)}, dlv[m], acc[m]);
         check({"stress_idle", sfx(m)}, dv[m], 0);
      end
      chk_en = 1'b0;

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/arb_merge_n.md
ARB_MERGE_N -- requirements
Module: arb_merge_n

Interface
REQ-001 Parameter DATA_WIDTH, default 32: width of every data word.
REQ-002 Parameter NUM_CH, default 4 (legal 2..16): number of input channels.
REQ-003 Parameter DEPTH, default 2 (legal power of two, 1..16): words buffered per channel.
REQ-004 Parameter ARB_MODE, default 0: 0 = fixed priority (lowest index wins), 1 = round-robin.
REQ-005 Port clk  input  1: single clock; all state changes on rising edge.
REQ-006 Port rstn  input  1: asynchronous, active-low reset.
REQ-007 Port i_drive_n  input  NUM_CH: per-channel valid.
REQ-008 Port i_data  input  NUM_CH*DATA_WIDTH: channel k occupies bits [k*DATA_WIDTH +: DATA_WIDTH].
REQ-009 Port o_free_n  output  NUM_CH: per-channel ready.
REQ-010 Port o_driveNext  output  1: output word valid.
REQ-011 Port o_data  output  DATA_WIDTH: output word.
REQ-012 Port o_src_id  output  clog2(NUM_CH), min 1: source channel of o_data.
REQ-013 Port i_freeNext  input  1: downstream ready.

Function
REQ-014 Input transfer on channel k SHALL occur at a rising edge where i_drive_n[k] & o_free_n[k]; the word is written to channel k's FIFO.
REQ-015 o_free_n[k] SHALL be 1 iff channel k FIFO holds fewer than DEPTH words; it is driven only from registered state (no combinational path from i_freeNext or i_drive_n).
REQ-016 Output transfer SHALL occur at a rising edge where o_driveNext & i_freeNext; o_data and o_src_id SHALL hold stable while o_driveNext=1 and i_freeNext=0.
REQ-017 Output register SHALL load when empty or being drained in the same cycle (zero-bubble throughput of 1 word/cycle).
REQ-018 When the output register loads, the arbiter SHALL grant exactly one non-empty channel FIFO, pop its head into o_data, and set o_src_id to its index; nothing is popped when no FIFO is non-empty.
REQ-019 Latency: a word accepted at edge t into an empty channel with an empty or draining output register SHALL appear with o_driveNext=1 after edge t+1.
REQ-020 ARB_MODE=0: grant the lowest-indexed non-empty channel.
REQ-021 ARB_MODE=1: a rotating pointer p (reset 0) gives priority p, p+1, ... NUM_CH-1, 0, ...; after grant to k, p becomes (k+1) mod NUM_CH; p SHALL not change when no grant occurs.
REQ-022 Simultaneous push and pop on one channel FIFO SHALL be legal at any occupancy below DEPTH, leaving count unchanged; at full, push is blocked by REQ-015 even if popping.
REQ-023 FIFO read/write pointers SHALL wrap modulo DEPTH; per-channel word order SHALL be preserved.
REQ-024 No word SHALL be lost or duplicated; cross-channel order is defined solely by the arbiter.

Reset
REQ-025 While rstn=0: all FIFOs empty, o_free_n = all ones, o_driveNext=0, o_data=0, o_src_id=0, RR pointer=0.
REQ-026 Reset asserted mid-operation SHALL discard all buffered words immediately; first transfer possible at the first rising edge after rstn deasserts.

Structure
REQ-027 Shared package arb_merge_pkg SHALL hold ARB_FIXED=0, ARB_RR=1 and the clog2 helper function.
REQ-028 One sub-module arb_merge_fifo (DATA_WIDTH, DEPTH; push/pop/full/empty/head) SHALL be instantiated NUM_CH times; arbiter and output register live in the top.

Verification
REQ-029 NUM_CH=4, mode 0, channels 0..3 each push one word (0xA0..0xA3) same edge, i_freeNext=1 -> output 0xA0,0xA1,0xA2,0xA3 on four consecutive cycles, src 0..3.
REQ-030 Mode 1, all four channels continuously valid, i_freeNext=1 for 12 cycles -> src sequence 0,1,2,3 repeated three times.
REQ-031 DEPTH=2, channel 2 pushes 0x11,0x22,0x33 with i_freeNext=0 -> o_free_n[2]=0 after two words held, 0x33 stalls until a slot frees; then outputs 0x11,0x22,0x33 in order.
REQ-032 i_freeNext=0 for 5 cycles with o_driveNext=1 -> o_data/o_src_id unchanged all 5 cycles; drain resumes on release with no loss.
REQ-033 rstn pulled low with 3 words buffered -> o_driveNext=0, o_data=0, o_free_n=4'b1111 immediately; no buffered word emerges after reset.
REQ-034 Random valid/ready stress, both modes, 10k words -> scoreboard per-channel order intact, zero loss/duplication.
